// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code set 2 sequencer: prefix/status
// byte constants, sequencer states and the packed key-event record.
package ps2_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FC = 8'hFC;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_FE = 8'hFE;
    localparam logic [7:0] SC_EE = 8'hEE;

    // Pause is E1 followed by seven more bytes that carry no extra meaning.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } ps2_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_ev_t;

    function automatic logic is_fault_code(input logic [7:0] b);
        return (b == SC_FC) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    function automatic logic is_ack_code(input logic [7:0] b);
        return (b == SC_FA) || (b == SC_FE) || (b == SC_EE);
    endfunction

endpackage

// File: rtl/ps2_ev_fifo.sv
// First-word fall-through FIFO of key events with an occupancy count.
// Pointers wrap naturally, so DEPTH must be a power of two.
module ps2_ev_fifo
    import ps2_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  ps2_ev_t       i_push_ev,
    input  logic          i_pop,
    output ps2_ev_t       o_head,
    output logic [CW-1:0] o_count
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    ps2_ev_t       r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the head is forced to zero while empty so outputs still read 0.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_ev;
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ps2_scan_ctrl.sv
// Scan-code set 2 sequencer behind the PS/2 frame receiver: assembles E0/F0/E1
// sequences into key events, tracks keyboard status and times out stalled prefixes.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int TIMEOUT_CYC  = 50000,
    parameter int AFULL_MARGIN = 2
) (
    input  logic       ck,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       rx_clr,
    output logic       inhibit,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       bat_ok,
    output logic       kb_fault,
    output logic       ovf,
    input  logic       stat_clr,
    output logic [7:0] err_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_t    r_state;
    ps2_state_t    w_state_nxt;
    logic [2:0]    r_skip;
    logic [2:0]    w_skip_nxt;
    logic [TW-1:0] r_to_cnt;
    logic          r_rx_clr;
    logic          r_inhibit;
    logic          r_bat_ok;
    logic          r_kb_fault;
    logic          r_ovf;
    logic [7:0]    r_err_cnt;

    logic          w_push;
    ps2_ev_t       w_push_ev;
    ps2_ev_t       w_head;
    logic [CW-1:0] w_count;
    logic          w_pop;
    logic          w_timeout;
    logic          w_set_bat;
    logic          w_set_fault;
    logic          w_ovf_set;

    assign w_timeout = (r_state != ST_IDLE) && !rx_valid && !rx_err
                       && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_skip_nxt     = r_skip;
        w_push         = 1'b0;
        w_push_ev.code = rx_data;
        w_push_ev.ext  = 1'b0;
        w_push_ev.brk  = 1'b0;
        w_set_bat      = 1'b0;
        w_set_fault    = 1'b0;

        if (rx_err) begin
            w_state_nxt = ST_IDLE;
        end else if (rx_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (rx_data == SC_E0)          w_state_nxt = ST_EXT;
                    else if (rx_data == SC_F0)     w_state_nxt = ST_BRK;
                    else if (rx_data == SC_E1) begin
                        w_state_nxt = ST_PAUSE;
                        w_skip_nxt  = PAUSE_SKIP;
                    end
                    else if (rx_data == SC_AA)     w_set_bat   = 1'b1;
                    else if (is_fault_code(rx_data)) w_set_fault = 1'b1;
                    else if (!is_ack_code(rx_data))  w_push      = 1'b1;
                end
                ST_EXT: begin
                    if (rx_data == SC_F0) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        w_push        = 1'b1;
                        w_push_ev.ext = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_push        = 1'b1;
                    w_push_ev.brk = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_push        = 1'b1;
                    w_push_ev.ext = 1'b1;
                    w_push_ev.brk = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
                ST_PAUSE: begin
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_push         = 1'b1;
                        w_push_ev.code = SC_E1;
                        w_state_nxt    = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_pop     = ev_valid && ev_ready;
    assign w_ovf_set = w_push && (w_count == CW'(FIFO_DEPTH)) && !w_pop;

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_skip     <= '0;
            r_to_cnt   <= '0;
            r_rx_clr   <= 1'b0;
            r_inhibit  <= 1'b0;
            r_bat_ok   <= 1'b0;
            r_kb_fault <= 1'b0;
            r_ovf      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_skip    <= w_skip_nxt;
            r_rx_clr  <= rx_err || w_timeout;
            r_inhibit <= (CW'(FIFO_DEPTH) - w_count) <= CW'(AFULL_MARGIN);

            if (r_state == ST_IDLE || rx_valid || rx_err || w_timeout) r_to_cnt <= '0;
            else                                                       r_to_cnt <= r_to_cnt + TW'(1);

            // Clearing wins over any set or increment landing in the same cycle.
            if (stat_clr) begin
                r_bat_ok   <= 1'b0;
                r_kb_fault <= 1'b0;
                r_ovf      <= 1'b0;
                r_err_cnt  <= '0;
            end else begin
                if (w_set_bat)   r_bat_ok   <= 1'b1;
                if (w_set_fault) r_kb_fault <= 1'b1;
                if (w_ovf_set)   r_ovf      <= 1'b1;
                if (rx_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    ps2_ev_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (ck),
        .rst_n     (reset),
        .i_push    (w_push),
        .i_push_ev (w_push_ev),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_count)
    );

    assign ev_valid = (w_count != '0);
    assign ev_code  = w_head.code;
    assign ev_ext   = w_head.ext;
    assign ev_break = w_head.brk;
    assign rx_clr   = r_rx_clr;
    assign inhibit  = r_inhibit;
    assign bat_ok   = r_bat_ok;
    assign kb_fault = r_kb_fault;
    assign ovf      = r_ovf;
    assign err_cnt  = r_err_cnt;

endmodule

// File: doc/ps2_scan_ctrl.md
Name: ps2_scan_ctrl

Overview:
- Sequencer sitting directly behind the PS/2 frame receiver, in the `ck` domain.
- Interprets the receiver's byte stream as scan-code set 2: E0 extended prefix, F0 break prefix, E1 Pause sequence, and keyboard status bytes.
- Emits complete key events through a FIFO with a valid/ready interface.
- Drives receiver clear and host-inhibit control back toward the PS/2 side, and times out stalled prefix sequences.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 4.
- TIMEOUT_CYC, 50000, ck cycles allowed between bytes of one multi-byte sequence (1 ms at 50 MHz).
- AFULL_MARGIN, 2, inhibit asserts when free entries <= this value.

Ports:
- ck  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from the receiver; valid only when rx_valid is high.
- rx_valid  in  1  one-ck pulse per received byte, already synchronised to ck.
- rx_err  in  1  one-ck pulse on parity or framing error.
- rx_clr  out  1  one-ck pulse that resets the receiver's bit counter.
- inhibit  out  1  request to hold PS/2 clock low; level signal.
- ev_code  out  8  event scan code (FIFO head).
- ev_ext  out  1  event carried the E0 prefix.
- ev_break  out  1  event is a key release.
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer pop; a pop occurs when ev_valid and ev_ready are both high.
- bat_ok  out  1  sticky; set on AA.
- kb_fault  out  1  sticky; set on FC, 00 or FF.
- ovf  out  1  sticky; event dropped because the FIFO was full.
- stat_clr  in  1  clears bat_ok, kb_fault and ovf; also resets err_cnt.
- err_cnt  out  8  saturating count of rx_err pulses.

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, timeout counter 0.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions are evaluated only on rx_valid cycles.
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip=7. Status bytes are handled per the status rule below. Any other byte pushes {code, ext=0, brk=0} and stays in IDLE.
  - EXT: F0 -> EXT_BRK; otherwise push {code, 1, 0} -> IDLE.
  - BRK: push {code, 0, 1} -> IDLE.
  - EXT_BRK: push {code, 1, 1} -> IDLE.
  - PAUSE: decrement skip on each byte. When skip reaches 0, push {E1, 0, 0} -> IDLE. No break event is ever emitted for Pause.
- Status bytes (AA, FC, 00, FF, FA, FE, EE) are acted on only in IDLE:
  - AA sets bat_ok; FC, 00 and FF set kb_fault.
  - FA, FE and EE are discarded.
  - None of these bytes produces an event. In any other state they are treated as ordinary codes.
- Timeout:
  - Counter is active in any state other than IDLE.
  - Cleared on every rx_valid; increments otherwise.
  - On reaching TIMEOUT_CYC: FSM -> IDLE, one-cycle rx_clr pulse, no push, counter cleared.
- rx_err:
  - Forces FSM -> IDLE and pulses rx_clr in the next cycle.
  - Increments err_cnt, saturating at 255.
  - If rx_err and rx_valid are high in the same cycle, rx_err wins and the byte is discarded.
- FIFO:
  - First-word fall-through; ev_* outputs reflect the head entry combinationally from the registered storage.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Occupancy count is one bit wider.
  - Push when full and no pop in the same cycle: entry dropped, ovf set.
  - Push and pop in the same cycle while full: both succeed and count is unchanged.
  - Push and pop in the same cycle while empty: the push lands; the pop is ignored because ev_valid was 0.
- inhibit is registered: high when (FIFO_DEPTH - count) <= AFULL_MARGIN, low otherwise; 1-cycle latency after count changes.
- stat_clr has priority over a same-cycle set of a sticky flag (clear wins); err_cnt returns to 0.
- Latency: the final byte of a sequence on rx_valid at cycle n gives ev_valid at cycle n+1 (FIFO previously empty).
- Asserting reset mid-sequence or with the FIFO non-empty discards everything immediately (asynchronous).

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code constants: E0, F0, E1, AA, FC, FA, FE, EE;
  - an FSM state enum;
  - a packed event struct {code[7:0], ext, brk}, 10 bits.
- One sub-module, ps2_ev_fifo: parameterised FWFT FIFO of ps2_pkg event structs with count output.
- FSM, timeout counter, status flags and error counter stay in ps2_scan_ctrl.

Test Plan:
- Bytes 1C, then F0 1C, with ev_ready=1 -> events {1C,0,0} then {1C,0,1}; ev_valid high one cycle after each final byte.
- E0 75, then E0 F0 75 -> {75,1,0} then {75,1,1}; FSM back in IDLE after each.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,0}; the F0 bytes inside the sequence produce no break event.
- E0, then no byte for TIMEOUT_CYC cycles -> rx_clr pulses once, no event; a following 1C yields {1C,0,0} (not extended).
- ev_ready=0, 9 codes with FIFO_DEPTH=8 -> inhibit high once count reaches 6, ovf set on the 9th, 8 events drained in order; stat_clr clears ovf.
- AA, then FC, then rx_err coinciding with rx_valid(1C) -> bat_ok=1, kb_fault=1, err_cnt=1, rx_clr pulse, no event for 1C.
